// File: rtl/alu_pkg.sv
// Shared ALU result-path types and constants.
// Widths, opcodes and the buffered entry record.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int DEST_W = 5;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_SLL  = 4'h5;
  localparam logic [3:0] ALU_SRL  = 4'h6;
  localparam logic [3:0] ALU_SRA  = 4'h7;
  localparam logic [3:0] ALU_SLT  = 4'h8;
  localparam logic [3:0] ALU_SLTU = 4'h9;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [3:0]        opcode;
    logic [DEST_W-1:0] dest;
    logic              zero;
    logic              neg;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/alu_skid_fifo2.sv
// Two-entry in-order buffer with valid/ready on both sides.
// Head data comes straight from storage registers.
module alu_skid_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] mem [2];
  logic [1:0]   count;
  logic         wr_ptr;
  logic         rd_ptr;
  logic         push;
  logic         pop;

  assign in_ready  = (count != 2'd2) && !flush;
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result buffer stage: tags results with zero/neg,
// buffers two entries, retires flags and a saturating count.
module alu_result_stage #(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int DEST_W = alu_pkg::DEST_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [3:0]        in_opcode,
  input  logic [DEST_W-1:0] in_dest,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [3:0]        out_opcode,
  output logic [DEST_W-1:0] out_dest,
  output logic              out_zero,
  output logic              out_neg,
  output logic              flag_zero,
  output logic              flag_neg,
  output logic [15:0]       retire_cnt
);

  localparam int EW = DATA_W + 4 + DEST_W + 2;

  logic [EW-1:0] push_data;
  logic [EW-1:0] head;
  logic          pop;

  assign push_data = {in_result, in_opcode, in_dest,
                      (in_result == '0), in_result[DATA_W-1]};

  assign {out_result, out_opcode, out_dest,
          out_zero, out_neg} = head;

  assign pop = out_valid && out_ready;

  alu_skid_fifo2 #(.W(EW)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (push_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head)
  );

  // A pop in a flush cycle still retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_zero  <= 1'b0;
      flag_neg   <= 1'b0;
      retire_cnt <= 16'd0;
    end else if (pop) begin
      flag_zero <= out_zero;
      flag_neg  <= out_neg;
      if (retire_cnt != 16'hFFFF)
        retire_cnt <= retire_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Randomized bench for alu_result_stage against a queue model.
// Model retires from a queue and tracks flags/count arithmetically.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_result = '0;
  logic [3:0]  in_opcode = '0;
  logic [4:0]  in_dest = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [3:0]  out_opcode;
  logic [4:0]  out_dest;
  logic        out_zero;
  logic        out_neg;
  logic        flag_zero;
  logic        flag_neg;
  logic [15:0] retire_cnt;

  alu_result_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_opcode  (in_opcode),
    .in_dest    (in_dest),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_opcode (out_opcode),
    .out_dest   (out_dest),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
    .flag_zero  (flag_zero),
    .flag_neg   (flag_neg),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r;
    logic [3:0]  op;
    logic [4:0]  d;
  } ent_t;

  ent_t q[$];
  int   rc;
  bit   fz;
  bit   fn;
  int   checks;
  int   errors;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rnd_data();
    case ($urandom_range(3))
      0:       return 32'h0;
      1:       return 32'h8000_0000 | 32'($urandom);
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic drive(bit v, logic [31:0] r, bit ordy, bit fl);
    in_valid  = v;
    in_result = r;
    in_opcode = 4'($urandom_range(9));
    in_dest   = 5'($urandom);
    out_ready = ordy;
    flush     = fl;
  endtask

  // Check everything before the edge, then advance the model.
  task automatic step();
    bit   pop;
    bit   push;
    ent_t e;
    @(negedge clk);
    check("in_ready", in_ready, q.size() != 2 && !flush);
    check("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("out_result", out_result, q[0].r);
      check("out_opcode", out_opcode, q[0].op);
      check("out_dest", out_dest, q[0].d);
      check("out_zero", out_zero, q[0].r == 0);
      check("out_neg", out_neg, q[0].r[31]);
    end
    check("flag_zero", flag_zero, fz);
    check("flag_neg", flag_neg, fn);
    check("retire_cnt", retire_cnt, rc);
    pop  = q.size() != 0 && out_ready;
    push = q.size() != 2 && !flush && in_valid;
    e    = '{in_result, in_opcode, in_dest};
    @(posedge clk);
    if (pop) begin
      fz = (q[0].r == 0);
      fn = q[0].r[31];
      if (rc < 65535) rc++;
      void'(q.pop_front());
    end
    if (flush) q.delete();
    else if (push) q.push_back(e);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 32'h0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_flag_zero", flag_zero, 0);
    check("rst_flag_neg", flag_neg, 0);
    check("rst_retire_cnt", retire_cnt, 0);
    check("rst_out_fields",
          {out_result, out_opcode, out_dest, out_zero, out_neg}, 0);
    q.delete();
    rc = 0;
    fz = 0;
    fn = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  int base;

  initial begin
    checks = 0;
    errors = 0;
    do_reset();

    // Single zero result retires and sets flag_zero.
    drive(1, 32'h0, 1, 0);
    step();
    drive(0, 32'h0, 1, 0);
    step();
    step();
    check("single_flag_zero", flag_zero, 1);
    check("single_retire", retire_cnt, 1);

    // Fill with out_ready low, then drain in order.
    drive(1, 32'h8000_0001, 0, 0);
    step();
    drive(1, 32'h0000_0005, 0, 0);
    step();
    drive(1, 32'h1234_5678, 0, 0);
    step();
    check("full_in_ready", in_ready, 0);
    drive(0, 32'h0, 1, 0);
    step();
    check("drain1_flag_neg", flag_neg, 1);
    step();
    check("drain2_flag_neg", flag_neg, 0);
    step();

    // Streaming: one push and one pop per cycle.
    base = rc;
    for (int i = 0; i < 100; i++) begin
      drive(1, rnd_data(), 1, 0);
      step();
      if (i > 0) check("stream_count1", {in_ready, out_valid}, 2'b11);
    end
    drive(0, 32'h0, 1, 0);
    step();
    check("stream_retired", retire_cnt, base + 100);

    // Flush while full, head still retires.
    drive(1, 32'h0000_00AA, 0, 0);
    step();
    drive(1, 32'h8000_00BB, 0, 0);
    step();
    base = rc;
    drive(1, 32'h0000_00CC, 1, 1);
    step();
    drive(0, 32'h0, 1, 0);
    step();
    check("flush_retire", retire_cnt, base + 1);
    check("flush_empty", out_valid, 0);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(3) != 0, rnd_data(),
            $urandom_range(2) != 0, $urandom_range(19) == 0);
      step();
    end

    // Reset with entries buffered discards them.
    drive(1, 32'h5555_0000, 0, 0);
    step();
    drive(1, 32'hAAAA_0000, 0, 0);
    step();
    do_reset();
    drive(0, 32'h0, 1, 0);
    step();

    // Saturation of retire_cnt.
    for (int i = 0; i < 70000 && rc < 16'hFFFE; i++) begin
      drive(1, rnd_data(), 1, 0);
      step();
    end
    check("preload_fffe", retire_cnt, 16'hFFFE);
    for (int i = 0; i < 4; i++) begin
      drive(1, rnd_data(), 1, 0);
      step();
    end
    check("saturate_ffff", retire_cnt, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter DATA_W, default 32, result width in bits.
REQ-002 Parameter DEST_W, default 5, destination register index width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream ALU result valid.
REQ-006 in_ready  output  1  stage can accept an entry this cycle.
REQ-007 in_result  input  DATA_W  ALU Result.
REQ-008 in_opcode  input  4  AluOpCode that produced in_result.
REQ-009 in_dest  input  DEST_W  destination register index.
REQ-010 flush  input  1  synchronous discard of all buffered entries.
REQ-011 out_valid  output  1  head entry valid to writeback.
REQ-012 out_ready  input  1  writeback accepts head entry.
REQ-013 out_result / out_opcode / out_dest  output  DATA_W / 4 / DEST_W  head entry fields.
REQ-014 out_zero  output  1  head entry result equals zero.
REQ-015 out_neg  output  1  head entry result MSB.
REQ-016 flag_zero, flag_neg  output  1 each  architectural flags of last retired entry.
REQ-017 retire_cnt  output  16  number of retired entries, saturating.

Function
REQ-018 Two-entry in-order buffer; occupancy count 0..2, held in a register.
REQ-019 in_ready = (count != 2) && !flush, combinational from registered count and flush only; no path from out_ready.
REQ-020 Push when in_valid && in_ready; pop when out_valid && out_ready.
REQ-021 out_valid = (count != 0); out_* fields driven from head entry registers, no combinational path from in_*.
REQ-022 Latency: entry pushed at edge N appears on out_* from cycle after edge N (one cycle) when buffer was empty.
REQ-023 out_zero computed at push as (in_result == 0) and stored with entry; out_neg = in_result[DATA_W-1] stored with entry.
REQ-024 Push and pop same cycle with count 1: count stays 1, new entry becomes head next cycle, ordering preserved.
REQ-025 Count 2: in_ready low; pop only; count goes to 1, second entry becomes head.
REQ-026 Count 0: out_valid low; out_ready ignored; flags and retire_cnt unchanged.
REQ-027 On each pop: flag_zero <= out_zero, flag_neg <= out_neg, retire_cnt increments.
REQ-028 retire_cnt saturates at 16'hFFFF; no wrap.
REQ-029 flush: count <= 0 next edge; a pop handshaking in the flush cycle still retires (flags and retire_cnt update); no push occurs in a flush cycle.
REQ-030 out_* data fields when out_valid low are don't-care but SHALL NOT contain X after reset.

Reset
REQ-031 rst_n low asynchronously clears count to 0, so in_ready=1 and out_valid=0 immediately.
REQ-032 Reset clears flag_zero, flag_neg, retire_cnt and all entry registers (out_result, out_opcode, out_dest, out_zero, out_neg read 0).
REQ-033 Reset mid-transfer discards all buffered entries; no retire is counted for the reset cycle.

Structure
REQ-034 Shared package alu_pkg holds DATA_W, DEST_W, ALU opcode constants and the entry record type {result, opcode, dest, zero, neg}.
REQ-035 Storage and pointer logic in one sub-module alu_skid_fifo2 (2-entry, valid/ready both sides); flag generation, flags and counter in the top.

Verification
REQ-036 Reset: rst_n low mid-cycle -> in_ready=1, out_valid=0, flag_zero=0, retire_cnt=0 without waiting for clk.
REQ-037 Single push in_result=0, out_ready=1 -> out_valid next cycle with out_zero=1, out_neg=0; after pop flag_zero=1, retire_cnt=1.
REQ-038 out_ready=0, push 32'h8000_0001 then 32'h0000_0005 -> in_ready=0 at count 2; release out_ready -> retire in order, out_neg 1 then 0.
REQ-039 Continuous push/pop with in_valid=out_ready=1 for 100 cycles -> throughput 1/cycle, count stays 1, retire_cnt=100, data order matches.
REQ-040 Buffer full, flush=1 with out_ready=1 -> head retires (retire_cnt+1), count 0 next cycle, in_ready low during flush.
REQ-041 Preload retire_cnt to 16'hFFFE via 65534 retires, retire 3 more -> retire_cnt holds 16'hFFFF.
